// File: rtl/rx_stream_checker.sv
// rx_stream_checker: RX AXI-stream sink that checks an incrementing 32-bit counter payload and keeps statistics.
// Define RX_CHECKER_FRAME_LEN_EN to add frame-length checking against FRAME_WORDS.
module rx_stream_checker #(
    parameter int DATA_W      = 32,
    parameter int THR_LOG2    = 5,
    parameter int FRAME_WORDS = 2048
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              clear,
    input  logic              out_0_valid,
    input  logic [DATA_W-1:0] out_0_bits_data,
    input  logic              out_0_bits_last,
    output logic              out_0_ready,
    output logic              locked,
    output logic              err_pulse,
    output logic [31:0]       word_count,
    output logic [15:0]       frame_count,
    output logic [15:0]       err_count,
    output logic [15:0]       len_err_count,
    output logic [DATA_W-1:0] last_err_data,
    output logic [DATA_W-1:0] expected
);
    typedef enum logic {SEEK, CHECK} state_e;
    state_e state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d, led_q, led_d;
    logic [31:0] wc_q, wc_d;
    logic [15:0] fc_q, fc_d, ec_q, ec_d;
    logic ep_q, ep_d, thr_hit, beat;
    generate
        if (THR_LOG2 == 0) begin : g_nothr
            assign thr_hit = 1'b1;
        end else begin : g_thr
            logic [THR_LOG2-1:0] thr_q;
            always_ff @(posedge clk or negedge aresetn)
                if (!aresetn) thr_q <= '0;
                else if (enable) thr_q <= thr_q + THR_LOG2'(1);
            assign thr_hit = &thr_q;
        end
    endgenerate
    // ready is kept low while in reset so nothing is accepted before the checker is initialised
    assign out_0_ready = aresetn & enable & ~clear & thr_hit;
    assign beat        = out_0_valid & out_0_ready;
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        led_d   = led_q;
        wc_d    = wc_q;
        fc_d    = fc_q;
        ec_d    = ec_q;
        ep_d    = 1'b0;
        if (clear) begin
            state_d = SEEK;
            exp_d   = '0;
            led_d   = '0;
            wc_d    = '0;
            fc_d    = '0;
            ec_d    = '0;
        end else if (beat) begin
            state_d = CHECK;
            exp_d   = out_0_bits_data + DATA_W'(1);
            wc_d    = wc_q + 32'd1;
            fc_d    = fc_q + {15'd0, out_0_bits_last};
            if (state_q == CHECK && out_0_bits_data != exp_q) begin
                ep_d  = 1'b1;
                ec_d  = (&ec_q) ? ec_q : ec_q + 16'd1;
                led_d = out_0_bits_data;
            end
        end
    end
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= SEEK;
            exp_q   <= '0;
            led_q   <= '0;
            wc_q    <= '0;
            fc_q    <= '0;
            ec_q    <= '0;
            ep_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            led_q   <= led_d;
            wc_q    <= wc_d;
            fc_q    <= fc_d;
            ec_q    <= ec_d;
            ep_q    <= ep_d;
        end
    end
`ifdef RX_CHECKER_FRAME_LEN_EN
    logic [15:0] bif_q, bif_d, bif_inc, lec_q, lec_d;
    logic arm_q, arm_d;
    // arm stays low through the first (partial) frame after SEEK so it is never length-checked
    always_comb begin
        bif_inc = bif_q + 16'd1;
        bif_d   = bif_q;
        lec_d   = lec_q;
        arm_d   = arm_q;
        if (clear) begin
            bif_d = '0;
            lec_d = '0;
            arm_d = 1'b0;
        end else if (beat) begin
            bif_d = out_0_bits_last ? 16'd0 : bif_inc;
            if (out_0_bits_last) begin
                arm_d = 1'b1;
                lec_d = (arm_q && bif_inc != 16'(FRAME_WORDS) && !(&lec_q)) ? lec_q + 16'd1 : lec_q;
            end
        end
    end
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bif_q <= '0;
            lec_q <= '0;
            arm_q <= 1'b0;
        end else begin
            bif_q <= bif_d;
            lec_q <= lec_d;
            arm_q <= arm_d;
        end
    end
    assign len_err_count = lec_q;
`else
    assign len_err_count = 16'(FRAME_WORDS) & 16'h0000;
`endif
    assign locked        = state_q == CHECK;
    assign err_pulse     = ep_q;
    assign word_count    = wc_q;
    assign frame_count   = fc_q;
    assign err_count     = ec_q;
    assign last_err_data = led_q;
    assign expected      = exp_q;
endmodule
